serial_uart_debug_ocimem_arbiter: RTL and testbench

Arbitrates the single-port on-chip debug RAM (OCI memory) between two requesters: the JTAG debug slave's system-clock command strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`, `jdo`) and the CPU's Avalon-MM debug-memory slave. It sequences JTAG address-load, write and read-with-auto-increment commands, and returns JTAG read data on `MonDReg`. It sits in the Nios II CPU debug subsystem, between the debug slave wrapper and the OCI RAM instance.

---
 rtl/serial_uart_debug_pkg.sv | 27 ++
 rtl/serial_uart_debug_rr_arb2.sv | 46 ++++
 rtl/serial_uart_debug_ocimem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_serial_uart_debug_ocimem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_uart_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_uart_debug_pkg
// Brief   : Shared types and jdo field layout for the OCI memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package serial_uart_debug_pkg;

    // jdo field positions
    localparam int unsigned c_JDO_W         = 38;
    localparam int unsigned c_JDO_ADDR_MSB  = 33;
    localparam int unsigned c_JDO_ADDR_LSB  = 26;
    localparam int unsigned c_JDO_WDATA_MSB = 34;
    localparam int unsigned c_JDO_WDATA_LSB = 3;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD_CPU  = 2'd1;
    localparam logic [1:0] c_ST_RD_JTAG = 2'd2;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } grant_e;

endpackage : serial_uart_debug_pkg
`default_nettype wire

// File: rtl/serial_uart_debug_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : serial_uart_debug_rr_arb2
// Brief   : Two-requester round-robin arbiter (JTAG vs CPU) with registered
//           last grant.
// Revision: 1.0 - initial release
// ============================================================================
module serial_uart_debug_rr_arb2
    import serial_uart_debug_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_enable,
    input  logic   i_req_jtag,
    input  logic   i_req_cpu,
    output logic   o_gnt_valid,
    output grant_e o_grant
);

    grant_e r_last_grant;
    logic   w_contested;

    assign w_contested = i_req_jtag & i_req_cpu;

    always_comb begin
        o_gnt_valid = i_enable & (i_req_jtag | i_req_cpu);
        if (w_contested) begin
            o_grant = (r_last_grant == GRANT_CPU) ? GRANT_JTAG : GRANT_CPU;
        end else if (i_req_jtag) begin
            o_grant = GRANT_JTAG;
        end else begin
            o_grant = GRANT_CPU;
        end
    end

    // History only moves on a tie, so the loser of one tie wins the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_CPU;
        end else if (i_enable && w_contested) begin
            r_last_grant <= o_grant;
        end
    end

endmodule : serial_uart_debug_rr_arb2
`default_nettype wire

// File: rtl/serial_uart_debug_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : serial_uart_debug_ocimem_arbiter
// Brief   : Shares the single-port OCI debug RAM between JTAG debug commands
//           and the CPU Avalon-MM debug-memory slave.
// Revision: 1.0 - initial release
// ============================================================================
module serial_uart_debug_ocimem_arbiter
    import serial_uart_debug_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic                 take_no_action_ocimem_a,
    input  logic [c_JDO_W-1:0]   jdo,
    output logic [DATA_W-1:0]    MonDReg,
    output logic                 jtag_busy,
    output logic                 jtag_overrun,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [DATA_W-1:0]    avs_writedata,
    output logic [DATA_W-1:0]    avs_readdata,
    output logic                 avs_waitrequest,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_wren,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_mon_dreg;
    logic [DATA_W-1:0] w_mon_dreg_nxt;
    logic [DATA_W-1:0] r_readdata;
    logic [DATA_W-1:0] w_readdata_nxt;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic [ADDR_W-1:0] w_jtag_addr_nxt;
    logic              r_pend_valid;
    logic              w_pend_valid_nxt;
    logic              r_pend_write;
    logic              w_pend_write_nxt;
    logic [DATA_W-1:0] r_pend_wdata;
    logic [DATA_W-1:0] w_pend_wdata_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;

    logic              w_gnt_valid;
    grant_e            w_grant;
    logic              w_jtag_done;
    logic              w_any_strobe;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_wren;
    logic [DATA_W-1:0] w_ram_wdata;
    logic              w_waitrequest;
    logic [DATA_W-1:0] w_readdata_out;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic [DATA_W-1:0] w_jdo_wdata;
    logic              w_jdo_unused;

    assign w_jdo_addr   = ADDR_W'(jdo[c_JDO_ADDR_MSB:c_JDO_ADDR_LSB]);
    assign w_jdo_wdata  = DATA_W'(jdo[c_JDO_WDATA_MSB:c_JDO_WDATA_LSB]);
    assign w_jdo_unused = ^{jdo[c_JDO_W-1:c_JDO_WDATA_MSB+1], jdo[c_JDO_WDATA_LSB-1:0]};
    assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    serial_uart_debug_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (reset),
        .i_enable    (r_state == c_ST_IDLE),
        .i_req_jtag  (r_pend_valid),
        .i_req_cpu   (avs_read | avs_write),
        .o_gnt_valid (w_gnt_valid),
        .o_grant     (w_grant)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_mon_dreg_nxt   = r_mon_dreg;
        w_readdata_nxt   = r_readdata;
        w_jtag_addr_nxt  = r_jtag_addr;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_write_nxt = r_pend_write;
        w_pend_wdata_nxt = r_pend_wdata;
        w_overrun_nxt    = r_overrun;
        w_jtag_done      = 1'b0;
        w_ram_addr       = '0;
        w_ram_wren       = 1'b0;
        w_ram_wdata      = '0;
        w_waitrequest    = 1'b1;
        w_readdata_out   = r_readdata;

        unique case (r_state)
            c_ST_IDLE: begin
                if (w_gnt_valid) begin
                    if (w_grant == GRANT_JTAG) begin
                        w_ram_addr = r_jtag_addr;
                        if (r_pend_write) begin
                            w_ram_wren  = 1'b1;
                            w_ram_wdata = r_pend_wdata;
                            w_jtag_done = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_RD_JTAG;
                        end
                    end else begin
                        w_ram_addr = avs_address;
                        if (avs_write) begin
                            w_ram_wren    = 1'b1;
                            w_ram_wdata   = avs_writedata;
                            w_waitrequest = 1'b0;
                        end else begin
                            w_state_nxt = c_ST_RD_CPU;
                        end
                    end
                end
            end
            c_ST_RD_CPU: begin
                // Data is presented live with waitrequest low, then held.
                w_readdata_nxt = ram_rdata;
                w_readdata_out = ram_rdata;
                w_waitrequest  = 1'b0;
                w_state_nxt    = c_ST_IDLE;
            end
            c_ST_RD_JTAG: begin
                w_mon_dreg_nxt = ram_rdata;
                w_jtag_done    = 1'b1;
                w_state_nxt    = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_jtag_done) begin
            w_pend_valid_nxt = 1'b0;
            w_jtag_addr_nxt  = r_jtag_addr + ADDR_W'(1);
        end

        // Completion and acceptance are exclusive: both depend on r_pend_valid.
        if (w_any_strobe) begin
            if (r_pend_valid) begin
                w_overrun_nxt = 1'b1;
            end else if (take_action_ocimem_a) begin
                w_jtag_addr_nxt = w_jdo_addr;
                if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                    w_overrun_nxt = 1'b1;
                end
            end else begin
                w_pend_valid_nxt = 1'b1;
                w_pend_write_nxt = take_action_ocimem_b;
                if (take_action_ocimem_b) begin
                    w_pend_wdata_nxt = w_jdo_wdata;
                end
                if (take_action_ocimem_b && take_no_action_ocimem_a) begin
                    w_overrun_nxt = 1'b1;
                end
            end
        end

        // A cycle with reset high never touches the RAM or completes a CPU access.
        if (reset) begin
            w_ram_addr     = '0;
            w_ram_wren     = 1'b0;
            w_ram_wdata    = '0;
            w_waitrequest  = 1'b1;
            w_readdata_out = r_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_mon_dreg   <= '0;
            r_readdata   <= '0;
            r_jtag_addr  <= '0;
            r_pend_valid <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_wdata <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mon_dreg   <= w_mon_dreg_nxt;
            r_readdata   <= w_readdata_nxt;
            r_jtag_addr  <= w_jtag_addr_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_write <= w_pend_write_nxt;
            r_pend_wdata <= w_pend_wdata_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign MonDReg         = r_mon_dreg;
    assign jtag_busy       = r_pend_valid;
    assign jtag_overrun    = r_overrun;
    assign avs_readdata    = w_readdata_out;
    assign avs_waitrequest = w_waitrequest;
    assign ram_addr        = w_ram_addr;
    assign ram_wren        = w_ram_wren;
    assign ram_wdata       = w_ram_wdata;

endmodule : serial_uart_debug_ocimem_arbiter
`default_nettype wire

// File: tb/tb_serial_uart_debug_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_uart_debug_ocimem_arbiter
// Brief   : Directed bench with a transaction-level model checked every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_uart_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        take_a = 1'b0, take_b = 1'b0, take_n = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] MonDReg, avs_readdata, ram_wdata, ram_rdata;
    logic        jtag_busy, jtag_overrun, avs_waitrequest, ram_wren;
    logic [7:0]  ram_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_uart_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .jdo                     (jdo),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 + 32'(a) * 32'd257;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM environment: one-cycle read latency, unwritten words read init_word()
    logic [31:0] tb_ram [256];
    bit          tb_wr  [256];
    logic [7:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        ram_rdata <= tb_wr[ram_addr] ? tb_ram[ram_addr] : init_word(int'(ram_addr));
        if (ram_wren) begin
            tb_ram[ram_addr] <= ram_wdata;
            tb_wr[ram_addr]  <= 1'b1;
            last_wr_addr     <= ram_addr;
            last_wr_data     <= ram_wdata;
            wr_count         <= wr_count + 1;
        end
    end

    // Transaction-level model: RAM port is either free or finishing a read
    logic [31:0] m_mem [256];
    bit          m_wr  [256];
    bit          m_rd_active = 0, m_rd_jtag = 0;
    logic [7:0]  m_rd_addr = '0;
    bit          m_jpend = 0, m_jwrite = 0;
    logic [31:0] m_jdata = '0;
    int          m_jaddr = 0;
    bit          m_last_tie_jtag = 0;
    logic [31:0] m_mondreg = '0, m_readdata = '0;
    bit          m_overrun = 0;

    function automatic logic [31:0] m_rd(input logic [7:0] a);
        return m_wr[a] ? m_mem[a] : init_word(int'(a));
    endfunction

    logic        e_wren, e_wait, e_issue;
    logic [31:0] e_rd, e_wdata;
    logic [7:0]  e_addr;
    bit          jp, creq, win_j;

    always @(negedge clk) begin
        chk("mondreg", MonDReg, m_mondreg);
        chk("jtag_busy", {31'd0, jtag_busy}, {31'd0, m_jpend});
        chk("jtag_overrun", {31'd0, jtag_overrun}, {31'd0, m_overrun});
        if (reset) begin
            chk("rst_wren", {31'd0, ram_wren}, 32'd0);
            chk("rst_wait", {31'd0, avs_waitrequest}, 32'd1);
            chk("rst_readdata", avs_readdata, m_readdata);
            m_rd_active = 0; m_jpend = 0; m_jaddr = 0; m_last_tie_jtag = 0;
            m_mondreg = '0; m_readdata = '0; m_overrun = 0;
        end else begin
            e_wren = 0; e_wait = 1; e_issue = 0; e_rd = m_readdata;
            e_addr = '0; e_wdata = '0;
            jp = m_jpend;
            if (m_rd_active) begin
                m_rd_active = 0;
                if (m_rd_jtag) begin
                    m_mondreg = m_rd(m_rd_addr);
                    m_jpend = 0;
                    m_jaddr = (m_jaddr + 1) % 256;
                end else begin
                    e_wait = 0;
                    e_rd = m_rd(m_rd_addr);
                    m_readdata = e_rd;
                end
            end else begin
                creq = avs_read | avs_write;
                if (jp && creq) begin
                    win_j = !m_last_tie_jtag;
                    m_last_tie_jtag = win_j;
                end else begin
                    win_j = jp;
                end
                if (win_j) begin
                    e_issue = 1; e_addr = 8'(m_jaddr);
                    if (m_jwrite) begin
                        e_wren = 1; e_wdata = m_jdata;
                        m_mem[e_addr] = m_jdata; m_wr[e_addr] = 1;
                        m_jpend = 0;
                        m_jaddr = (m_jaddr + 1) % 256;
                    end else begin
                        m_rd_active = 1; m_rd_jtag = 1; m_rd_addr = e_addr;
                    end
                end else if (creq) begin
                    e_issue = 1; e_addr = avs_address;
                    if (avs_write) begin
                        e_wren = 1; e_wdata = avs_writedata; e_wait = 0;
                        m_mem[e_addr] = avs_writedata; m_wr[e_addr] = 1;
                    end else begin
                        m_rd_active = 1; m_rd_jtag = 0; m_rd_addr = e_addr;
                    end
                end
            end
            if (take_a || take_b || take_n) begin
                if (jp) begin
                    m_overrun = 1;
                end else if (take_a) begin
                    m_jaddr = int'(jdo[33:26]);
                    if (take_b || take_n) m_overrun = 1;
                end else if (take_b) begin
                    m_jpend = 1; m_jwrite = 1; m_jdata = jdo[34:3];
                    if (take_n) m_overrun = 1;
                end else begin
                    m_jpend = 1; m_jwrite = 0;
                end
            end
            chk("ram_wren", {31'd0, ram_wren}, {31'd0, e_wren});
            chk("waitrequest", {31'd0, avs_waitrequest}, {31'd0, e_wait});
            chk("readdata", avs_readdata, e_rd);
            if (e_issue) chk("ram_addr", {24'd0, ram_addr}, {24'd0, e_addr});
            if (e_wren) chk("ram_wdata", ram_wdata, e_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] a);
        take_a = 1'b1; jdo = {4'b0, a, 26'b0};
        step();
        take_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] d);
        take_b = 1'b1; jdo = {3'b0, d, 3'b0};
        step();
        take_b = 1'b0;
    endtask

    task automatic pulse_n();
        take_n = 1'b1;
        step();
        take_n = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (avs_waitrequest && cyc < 8) begin
            step();
            cyc++;
        end
        if (avs_waitrequest) chk("waitrequest_timeout", 32'd1, 32'd0);
    endtask

    int cyc;
    int w0;

    initial begin
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("reset_mondreg", MonDReg, 32'd0);
        chk("reset_readdata", avs_readdata, 32'd0);
        chk("reset_wait", {31'd0, avs_waitrequest}, 32'd1);
        chk("reset_wren", {31'd0, ram_wren}, 32'd0);
        chk("reset_addr", {24'd0, ram_addr}, 32'd0);
        chk("reset_wdata", ram_wdata, 32'd0);
        chk("reset_busy", {31'd0, jtag_busy}, 32'd0);
        chk("reset_overrun", {31'd0, jtag_overrun}, 32'd0);
        step();

        // JTAG write at loaded address
        pulse_a(8'h10);
        pulse_b(32'hDEADBEEF);
        chk("jwr_busy", {31'd0, jtag_busy}, 32'd1);
        chk("jwr_wren", {31'd0, ram_wren}, 32'd1);
        chk("jwr_addr", {24'd0, ram_addr}, 32'h10);
        chk("jwr_wdata", ram_wdata, 32'hDEADBEEF);
        step();
        chk("jwr_busy_low", {31'd0, jtag_busy}, 32'd0);
        chk("jwr_ram", tb_ram[8'h10], 32'hDEADBEEF);

        // JTAG read, then write lands at the auto-incremented address
        pulse_a(8'h10);
        pulse_n();
        chk("jrd_busy", {31'd0, jtag_busy}, 32'd1);
        step();
        chk("jrd_not_early", MonDReg, 32'd0);
        step();
        chk("jrd_mondreg", MonDReg, 32'hDEADBEEF);
        chk("jrd_busy_low", {31'd0, jtag_busy}, 32'd0);
        pulse_b(32'hCAFEF00D);
        step();
        chk("jinc_addr", {24'd0, last_wr_addr}, 32'h11);
        chk("jinc_data", last_wr_data, 32'hCAFEF00D);

        // CPU write then read
        avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h12345678;
        #1;
        chk("cwr_wait_low", {31'd0, avs_waitrequest}, 32'd0);
        step();
        avs_write = 1'b0; avs_read = 1'b1;
        #1;
        chk("crd_wait_c1", {31'd0, avs_waitrequest}, 32'd1);
        step();
        chk("crd_wait_c2", {31'd0, avs_waitrequest}, 32'd0);
        chk("crd_data", avs_readdata, 32'h12345678);
        avs_read = 1'b0;
        step();

        // Round-robin ties after reset: JTAG first, then CPU first
        reset = 1'b1; step(); reset = 1'b0;
        pulse_a(8'h10);
        pulse_n();
        avs_read = 1'b1; avs_address = 8'h20;
        #1;
        chk("tie1_jtag_addr", {24'd0, ram_addr}, 32'h10);
        wait_ready(cyc);
        chk("tie1_cpu_wait", 32'(cyc), 32'd3);
        chk("tie1_cpu_data", avs_readdata, 32'h12345678);
        chk("tie1_mondreg", MonDReg, 32'hDEADBEEF);
        avs_read = 1'b0;
        step();
        pulse_n();
        avs_read = 1'b1;
        #1;
        chk("tie2_cpu_addr", {24'd0, ram_addr}, 32'h20);
        wait_ready(cyc);
        chk("tie2_cpu_wait", 32'(cyc), 32'd1);
        avs_read = 1'b0;
        step();
        chk("tie2_jtag_addr", {24'd0, ram_addr}, 32'h11);
        step(); step();
        chk("tie2_mondreg", MonDReg, 32'hCAFEF00D);

        // Address wrap and overrun
        pulse_a(8'hFF);
        w0 = wr_count;
        pulse_n();
        pulse_b(32'h11111111);
        chk("ovr_flag", {31'd0, jtag_overrun}, 32'd1);
        step();
        chk("wrap_rd_ff", MonDReg, 32'hA5A5FFFF);
        chk("wrap_busy_low", {31'd0, jtag_busy}, 32'd0);
        pulse_n();
        chk("wrap_addr0", {24'd0, ram_addr}, 32'h00);
        step(); step();
        chk("wrap_rd_00", MonDReg, 32'hA5A50000);
        chk("ovr_no_write", 32'(wr_count), 32'(w0));

        // Reset during RD_CPU
        avs_read = 1'b1; avs_address = 8'h20;
        step();
        reset = 1'b1; avs_read = 1'b0;
        #1;
        chk("rstrd_wait_in_reset", {31'd0, avs_waitrequest}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        chk("rstrd_wait", {31'd0, avs_waitrequest}, 32'd1);
        chk("rstrd_readdata", avs_readdata, 32'd0);
        chk("rstrd_wren", {31'd0, ram_wren}, 32'd0);
        chk("rstrd_overrun", {31'd0, jtag_overrun}, 32'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_uart_debug_ocimem_arbiter
`default_nettype wire
